// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand-issue stage with register file, scoreboard and registered ALU bundle
// Optional statistics counters: define ALU_ISSUE_STATS_EN.
module alu_issue_stage #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] operand1,
  output logic [DW-1:0] operand2,
  output logic [AW-1:0] out_rd,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]   issue_count,
  output logic [31:0]   stall_count
`endif
);

  localparam int NREGS = 2 ** AW;

  logic [DW-1:0]    regs_q [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [2:0]       op_q;
  logic [DW-1:0]    op1_q, op2_q;
  logic [AW-1:0]    rd_q;

  logic          wb_hit1, wb_hit2, wb_hitd;
  logic          haz1, haz2, hazd, hazard, issue;
  logic [DW-1:0] src1, src2;

  // A writeback this cycle both forwards its data and clears the matching hazard.
  assign wb_hit1 = wb_valid && (wb_rd == in_rs1);
  assign wb_hit2 = wb_valid && (wb_rd == in_rs2);
  assign wb_hitd = wb_valid && (wb_rd == in_rd);

  assign haz1   = pending_q[in_rs1] && (in_rs1 != '0) && !wb_hit1;
  assign haz2   = pending_q[in_rs2] && (in_rs2 != '0) && !in_use_imm && !wb_hit2;
  assign hazd   = pending_q[in_rd] && (in_rd != '0) && !wb_hitd;
  assign hazard = haz1 || haz2 || hazd;

  assign in_ready = (!valid_q || out_ready) && !hazard;
  assign issue    = in_valid && in_ready;

  assign src1 = (in_rs1 == '0) ? '0 : (wb_hit1 ? wb_data : regs_q[in_rs1]);
  assign src2 = in_use_imm ? in_imm :
                ((in_rs2 == '0) ? '0 : (wb_hit2 ? wb_data : regs_q[in_rs2]));

  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    if (wb_valid && (wb_rd != '0)) pending_d[wb_rd] = 1'b0;
    // Applied after the clear so a same-rd issue keeps the register pending.
    if (issue && (in_rd != '0)) pending_d[in_rd] = 1'b1;
    if (issue) valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      op_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
    end else begin
      if (wb_valid && (wb_rd != '0)) regs_q[wb_rd] <= wb_data;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      if (issue) begin
        op_q  <= in_op;
        op1_q <= src1;
        op2_q <= src2;
        rd_q  <= in_rd;
      end
    end
  end

  assign out_valid = valid_q;
  assign alu_op    = op_q;
  assign operand1  = op1_q;
  assign operand2  = op2_q;
  assign out_rd    = rd_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (in_valid && hazard) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic        out_valid, out_ready;
  logic [2:0]  alu_op;
  logic [31:0] operand1, operand2;
  logic [2:0]  out_rd;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.AW(3), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .operand1(operand1), .operand2(operand2), .out_rd(out_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef ALU_ISSUE_STATS_EN
    , .issue_count(issue_count), .stall_count(stall_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [2:0] rd, input logic use_imm, input logic [31:0] imm);
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_use_imm = use_imm; in_imm = imm;
    #1;
  endtask

  task automatic do_wb(input logic [2:0] rd, input logic [31:0] data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_imm = '0; in_use_imm = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || operand1 !== 32'd0 || operand2 !== 32'd0 || alu_op !== 3'd0 || out_rd !== 3'd0) begin
      errors++; $display("FAIL reset_outputs: v=%b op=%0d o1=%h o2=%h rd=%0d, expected all 0", out_valid, alu_op, operand1, operand2, out_rd);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef ALU_ISSUE_STATS_EN
    checks++;
    if (issue_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_stats: issue=%0d stall=%0d expected 0 0", issue_count, stall_count);
    end
`endif
  endtask

  task automatic test_issue();
    do_wb(3'd1, 32'd10);
    do_wb(3'd2, 32'd10);
    drive_in(3'd0, 3'd1, 3'd2, 3'd4, 1'b0, 32'd0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || operand1 !== 32'd10 || operand2 !== 32'd10 || out_rd !== 3'd4 || alu_op !== 3'd0) begin
      errors++; $display("FAIL issue_bundle: v=%b op=%0d o1=%0d o2=%0d rd=%0d, expected 1 0 10 10 4", out_valid, alu_op, operand1, operand2, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || operand1 !== 32'd10 || out_rd !== 3'd4) begin
      errors++; $display("FAIL drain: v=%b o1=%0d rd=%0d, expected 0 10 4", out_valid, operand1, out_rd);
    end
`ifdef ALU_ISSUE_STATS_EN
    checks++;
    if (issue_count !== 32'd1) begin errors++; $display("FAIL stats_issue: got %0d expected 1", issue_count); end
`endif
    do_wb(3'd4, 32'h20);
  endtask

  task automatic test_hazard();
    drive_in(3'd1, 3'd1, 3'd2, 3'd3, 1'b0, 32'd0);
    tick();
    drive_in(3'd5, 3'd3, 3'd0, 3'd5, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall%0d: got %b expected 0", i, in_ready); end
      tick();
    end
`ifdef ALU_ISSUE_STATS_EN
    checks++;
    if (stall_count !== 32'd2) begin errors++; $display("FAIL stats_stall: got %0d expected 2", stall_count); end
`endif
    wb_valid = 1'b1; wb_rd = 3'd3; wb_data = 32'h55;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready: got %b expected 1", in_ready); end
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || operand1 !== 32'h55 || operand2 !== 32'd0 || out_rd !== 3'd5 || alu_op !== 3'd5) begin
      errors++; $display("FAIL raw_bypass_bundle: v=%b op=%0d o1=%h o2=%h rd=%0d, expected 1 5 55 0 5", out_valid, alu_op, operand1, operand2, out_rd);
    end
    drive_in(3'd0, 3'd0, 3'd0, 3'd5, 1'b0, 32'd0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall: got %b expected 0", in_ready); end
    drive_in(3'd6, 3'd1, 3'd5, 3'd6, 1'b1, 32'hABCD);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL imm_ignores_rs2: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (operand1 !== 32'd10 || operand2 !== 32'hABCD || out_rd !== 3'd6) begin
      errors++; $display("FAIL imm_bundle: o1=%h o2=%h rd=%0d, expected a abcd 6", operand1, operand2, out_rd);
    end
    do_wb(3'd5, 32'h66);
    do_wb(3'd6, 32'h77);
  endtask

  task automatic test_hold();
    logic [31:0] o1_hold;
    drive_in(3'd2, 3'd1, 3'd0, 3'd7, 1'b1, 32'h1234);
    tick();
    out_ready = 1'b0;
    drive_in(3'd3, 3'd2, 3'd1, 3'd6, 1'b0, 32'd0);
    o1_hold = 32'd10;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_op !== 3'd2 || out_rd !== 3'd7 ||
          operand1 !== o1_hold || operand2 !== 32'h1234) begin
        errors++; $display("FAIL hold%0d: rdy=%b v=%b op=%0d rd=%0d o1=%h o2=%h, expected 0 1 2 7 a 1234",
                           i, in_ready, out_valid, alu_op, out_rd, operand1, operand2);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL back_to_back_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_op !== 3'd3 || out_rd !== 3'd6 || operand1 !== 32'd10 || operand2 !== 32'd10) begin
      errors++; $display("FAIL back_to_back_bundle: v=%b op=%0d rd=%0d o1=%0d o2=%0d, expected 1 3 6 10 10",
                         out_valid, alu_op, out_rd, operand1, operand2);
    end
    do_wb(3'd7, 32'd1);
    do_wb(3'd6, 32'd2);
  endtask

  task automatic test_zero_reg();
    drive_in(3'd4, 3'd0, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF);
    tick();
    drive_in(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 32'd0);
    checks++;
    if (operand1 !== 32'd0 || operand2 !== 32'hFFFF_FFFF || out_rd !== 3'd0) begin
      errors++; $display("FAIL zero_imm_bundle: o1=%h o2=%h rd=%0d, expected 0 ffffffff 0", operand1, operand2, out_rd);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL r0_not_pending: got %b expected 1", in_ready); end
    in_valid = 1'b0;
    do_wb(3'd0, 32'd7);
    drive_in(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (operand1 !== 32'd0 || operand2 !== 32'd0) begin
      errors++; $display("FAIL r0_stays_zero: o1=%h o2=%h expected 0 0", operand1, operand2);
    end
  endtask

  task automatic test_wb_issue_same_rd();
    wb_valid = 1'b1; wb_rd = 3'd3; wb_data = 32'h99;
    drive_in(3'd1, 3'd1, 3'd0, 3'd3, 1'b0, 32'd0);
    tick();
    wb_valid = 1'b0;
    drive_in(3'd0, 3'd3, 3'd0, 3'd1, 1'b0, 32'd0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL set_wins_pending: got %b expected 0", in_ready); end
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_hold();
    drive_in(3'd2, 3'd1, 3'd2, 3'd7, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_hold: got %b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || operand1 !== 32'd0 || operand2 !== 32'd0 || out_rd !== 3'd0 || alu_op !== 3'd0) begin
      errors++; $display("FAIL async_reset: v=%b op=%0d o1=%h o2=%h rd=%0d, expected all 0", out_valid, alu_op, operand1, operand2, out_rd);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive_in(3'd0, 3'd7, 3'd3, 3'd7, 1'b0, 32'd0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_clears_pending: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (operand1 !== 32'd0 || operand2 !== 32'd0) begin
      errors++; $display("FAIL reset_clears_regs: o1=%h o2=%h expected 0 0", operand1, operand2);
    end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_hazard();
    test_hold();
    test_zero_reg();
    test_wb_issue_same_rd();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the ALU (alu_op[2:0], operand1, operand2 -> result, zero).
- Accepts decoded instructions, reads operands from an internal register file, and tracks pending destinations with a 1-bit-per-register scoreboard.
- Drives a registered, valid/ready-handshaked operand bundle to the ALU.
- ALU results return on a writeback port that updates the register file and clears the scoreboard.

Parameters:
- AW, 3, register index width; NREGS = 2**AW registers, register 0 hardwired to zero.
- DW, 32, data width; must match ALU operand width.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decoded instruction valid
- in_ready  output  1  stage accepts instruction this cycle
- in_op  input  3  ALU opcode, passed through to alu_op
- in_rs1  input  AW  source register 1
- in_rs2  input  AW  source register 2
- in_rd  input  AW  destination register
- in_imm  input  DW  immediate
- in_use_imm  input  1  1: operand2 = in_imm, rs2 not read
- out_valid  output  1  operand bundle valid to ALU
- out_ready  input  1  downstream accepts bundle
- alu_op  output  3  opcode to ALU
- operand1  output  DW  ALU operand 1
- operand2  output  DW  ALU operand 2
- out_rd  output  AW  destination tag travelling with bundle
- wb_valid  input  1  writeback valid
- wb_rd  input  AW  writeback destination
- wb_data  input  DW  writeback data (ALU result)

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; alu_op, operand1, operand2, out_rd = 0.
  - All registers and pending[] = 0.
  - Any in-flight bundle is discarded.
  - in_ready is combinational and follows the rules below from the cleared state.
- Operand source, per operand (register 0 always reads 0):
  - if wb_valid && wb_rd==rs && rs!=0, then wb_data (same-cycle bypass);
  - else regfile[rs].
- Hazard: stall when any of the following holds, unless the same-cycle writeback bypass resolves it:
  - pending[in_rs1] && in_rs1!=0;
  - pending[in_rs2] && in_rs2!=0 && !in_use_imm;
  - pending[in_rd] && in_rd!=0 (WAW).
- in_ready = (!out_valid || out_ready) && !hazard.
- Issue (in_valid && in_ready):
  - Next cycle: out_valid=1; alu_op, operand1, operand2 (in_imm if in_use_imm), out_rd registered.
  - Latency: exactly 1 cycle.
  - pending[in_rd] set if in_rd!=0.
- Hold: while out_valid && !out_ready, all outputs are stable and no new instruction is accepted.
- Drain: out_valid && out_ready with no issue -> out_valid=0 next cycle; other outputs keep their last values.
- Writeback (wb_valid):
  - regfile[wb_rd] <= wb_data and pending[wb_rd] cleared, if wb_rd!=0.
  - wb_rd==0 is ignored.
  - Writeback to a non-pending register still writes.
- Simultaneous writeback and issue to the same rd: the set wins (pending stays 1) and the register takes wb_data.
- Back-to-back: accepting a new instruction in the same cycle the bundle is consumed is permitted (full throughput).
- Operands are unsigned bit vectors; no width conversion.

Optional Feature:
- ALU_ISSUE_STATS_EN defined: adds outputs issue_count[31:0] and stall_count[31:0].
  - issue_count increments per issue.
  - stall_count increments each cycle in_valid && hazard.
  - Both cleared by reset, wrap at 2^32.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with out_valid=1 mid-hold -> out_valid=0, outputs 0, pending cleared, in_ready=1 after release.
- Issue op=000 rs1=1, rs2=2 after wb r1=10, r2=10; out_ready=1 -> next cycle out_valid=1, operand1=10, operand2=10, out_rd as given.
- Issue rd=3, then rs1=3 with no wb -> in_ready=0 for stall cycles; wb r3=0x55 -> same cycle in_ready=1, operand1=0x55.
- out_ready=0 for 3 cycles with a new valid instruction -> outputs stable, in_ready=0; on out_ready=1 the new bundle appears next cycle.
- rs1=0, rd=0, in_use_imm=1, imm=0xFFFFFFFF -> operand1=0, operand2=0xFFFFFFFF, no pending set; wb to r0 of 7 leaves r0=0.
- ALU_ISSUE_STATS_EN: 5 issues, 2 stall cycles -> issue_count=5, stall_count=2.
